alu_execute_unit: RTL

//  EX-stage ALU that consumes the decoded {aluOp, useSign} control pair plus operands and produces a registered result.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_shift_sequencer.sv | 51 +++++
 rtl/alu_execute_unit.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU encodings for the EX-stage execute unit and the ALU control decoder.
package alu_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_NOR = 4'd4,
        OP_SLL = 4'd5,
        OP_SRL = 4'd6,
        OP_SLT = 4'd7
    } alu_op_e;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } exec_state_e;

    function automatic logic is_shift_op(input logic [ALU_OP_W-1:0] op);
        return (op == OP_SLL) || (op == OP_SRL);
    endfunction

endpackage

// File: rtl/alu_shift_sequencer.sv
// Iterative logical shifter: moves the working word by up to SHIFT_STEP bits per
// active cycle and pulses done on the cycle whose step consumes the last bits.
module alu_shift_sequencer #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 8,
    localparam int SHAMT_W   = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               active,
    input  logic               shift_left,
    input  logic [WIDTH-1:0]   operand,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   shifted,
    output logic               done
);

    // One extra bit so a step equal to WIDTH is representable.
    localparam int REM_W = SHAMT_W + 1;
    localparam logic [REM_W-1:0] STEP = REM_W'(SHIFT_STEP);

    logic [WIDTH-1:0] work_q;
    logic [REM_W-1:0] rem_q;
    logic [REM_W-1:0] rem_d;
    logic [REM_W-1:0] step;
    logic             left_q;

    always_comb begin
        step    = (rem_q > STEP) ? STEP : rem_q;
        rem_d   = rem_q - step;
        shifted = left_q ? (work_q << step) : (work_q >> step);
        done    = active && (rem_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work_q <= '0;
            rem_q  <= '0;
            left_q <= 1'b0;
        end else if (load) begin
            work_q <= operand;
            rem_q  <= {1'b0, shamt};
            left_q <= shift_left;
        end else if (active) begin
            work_q <= shifted;
            rem_q  <= rem_d;
        end
    end

endmodule

// File: rtl/alu_execute_unit.sv
// EX-stage ALU: single-cycle arithmetic/logic, iterative shifts, registered result
// with valid/ready handshakes on both sides and a synchronous flush.
module alu_execute_unit
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 8,
    localparam int SHAMT_W   = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic                use_sign,
    input  logic [WIDTH-1:0]    operand_a,
    input  logic [WIDTH-1:0]    operand_b,
    input  logic [SHAMT_W-1:0]  shamt,
    input  logic [4:0]          dest_reg,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    result,
    output logic                zero,
    output logic                overflow,
    output logic [4:0]          out_dest_reg
);

    exec_state_e      state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic [4:0]       dest_q, dest_d;
    logic [4:0]       pend_dest_q, pend_dest_d;

    logic             accept;
    logic             shift_start;
    logic             seq_done;
    logic [WIDTH-1:0] seq_shifted;
    logic [WIDTH-1:0] add_res;
    logic [WIDTH-1:0] sub_res;
    logic             slt_lt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    assign add_res = operand_a + operand_b;
    assign sub_res = operand_a - operand_b;
    assign slt_lt  = use_sign ? ($signed(operand_a) < $signed(operand_b))
                              : (operand_a < operand_b);

    // Shift codes only reach this path with shamt == 0, where the result is operand_b.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (alu_op)
            OP_ADD: begin
                alu_res = add_res;
                alu_ovf = use_sign && (operand_a[WIDTH-1] == operand_b[WIDTH-1])
                          && (add_res[WIDTH-1] != operand_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_res;
                alu_ovf = use_sign && (operand_a[WIDTH-1] != operand_b[WIDTH-1])
                          && (sub_res[WIDTH-1] != operand_a[WIDTH-1]);
            end
            OP_AND:         alu_res = operand_a & operand_b;
            OP_OR:          alu_res = operand_a | operand_b;
            OP_NOR:         alu_res = ~(operand_a | operand_b);
            OP_SLL, OP_SRL: alu_res = operand_b;
            OP_SLT:         alu_res = {{(WIDTH-1){1'b0}}, slt_lt};
            default:        alu_res = '0;
        endcase
    end

    assign in_ready    = (state_q == IDLE) && !flush && (!out_valid_q || out_ready);
    assign accept      = in_valid && in_ready;
    assign shift_start = accept && is_shift_op(alu_op) && (shamt != '0);

    alu_shift_sequencer #(
        .WIDTH      (WIDTH),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shift_seq (
        .clk        (clk),
        .reset      (reset),
        .load       (shift_start),
        .active     (state_q == SHIFT),
        .shift_left (alu_op == OP_SLL),
        .operand    (operand_b),
        .shamt      (shamt),
        .shifted    (seq_shifted),
        .done       (seq_done)
    );

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        dest_d      = dest_q;
        pend_dest_d = pend_dest_q;
        if (flush) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            if (state_q == SHIFT) begin
                if (seq_done) begin
                    result_d    = seq_shifted;
                    zero_d      = (seq_shifted == '0);
                    ovf_d       = 1'b0;
                    dest_d      = pend_dest_q;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end else if (accept) begin
                // An accept implies the old result retires this edge, so a shift start leaves out_valid low.
                if (shift_start) begin
                    pend_dest_d = dest_reg;
                    state_d     = SHIFT;
                end else begin
                    result_d    = alu_res;
                    zero_d      = (alu_res == '0);
                    ovf_d       = alu_ovf;
                    dest_d      = dest_reg;
                    out_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            dest_q      <= '0;
            pend_dest_q <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            dest_q      <= dest_d;
            pend_dest_q <= pend_dest_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign result       = result_q;
    assign zero         = zero_q;
    assign overflow     = ovf_q;
    assign out_dest_reg = dest_q;

endmodule
